// File: rtl/mem_stage_param_if.sv
// Operation bus into the memory stage and completion bus out of it.
// Handshake: an op transfers on a rising edge where in_valid & in_ready are both 1;
// the op fields must be stable while in_valid is high. out_valid is a one-cycle pulse
// with no back-pressure; downstream must take the result in that cycle.
interface mem_stage_param_if #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 2
);
  logic              in_valid;
  logic              in_ready;
  logic              wr, wm, rm, neq, j, jc, zero;
  logic [DATA_W-1:0] pc, alu_out, reg_val;
  logic [RD_W-1:0]   rd_ex;
  logic              out_valid, wr_mem, rm_mem, jump_taken, addr_err;
  logic [RD_W-1:0]   rd_mem;
  logic [DATA_W-1:0] alu_wb, data_out, jump_target;

  modport master (
    output in_valid, wr, wm, rm, neq, j, jc, zero, pc, alu_out, reg_val, rd_ex,
    input  in_ready, out_valid, wr_mem, rm_mem, jump_taken, addr_err,
    input  rd_mem, alu_wb, data_out, jump_target
  );

  modport slave (
    input  in_valid, wr, wm, rm, neq, j, jc, zero, pc, alu_out, reg_val, rd_ex,
    output in_ready, out_valid, wr_mem, rm_mem, jump_taken, addr_err,
    output rd_mem, alu_wb, data_out, jump_target
  );
endinterface

// File: rtl/mem_stage_param.sv
// Memory pipeline stage: data memory access with optional wait states, branch resolution
// and register-writeback pass-through. One op in flight at a time.
module mem_stage_param #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_W   = 2,
  parameter int WAIT   = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  mem_stage_param_if.slave bus,
  output logic             debug_state
);
  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W:0] DEPTH_V = (DATA_W + 1)'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic              wr, wm, rm, neq, j, jc, zero;
    logic [DATA_W-1:0] pc, alu_out, reg_val;
    logic [RD_W-1:0]   rd_ex;
  } op_t;

  state_t            state, next_state;
  logic [3:0]        cnt, next_cnt;
  logic              accept, complete;
  op_t               live_op, cap_op, cur_op;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range, mem_acc, take;
  logic [AW-1:0]     mem_idx;

  assign live_op = {bus.wr, bus.wm, bus.rm, bus.neq, bus.j, bus.jc, bus.zero,
                    bus.pc, bus.alu_out, bus.reg_val, bus.rd_ex};

  assign bus.in_ready = (state == IDLE) && reset_n;
  assign debug_state  = (state == BUSY);

  // cur_op is the op completing this edge: the live bus for immediate ops,
  // the captured copy when finishing a waited access.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    complete   = 1'b0;
    cur_op     = cap_op;
    case (state)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          accept = 1'b1;
          cur_op = live_op;
          if ((live_op.rm || live_op.wm) && (WAIT != 0)) begin
            next_state = BUSY;
            next_cnt   = 4'(WAIT);
          end else begin
            complete = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          complete   = 1'b1;
          next_state = IDLE;
          next_cnt   = 4'd0;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) cap_op <= live_op;
  end

  assign in_range = ({1'b0, cur_op.alu_out} < DEPTH_V);
  assign mem_acc  = cur_op.rm || cur_op.wm;
  assign mem_idx  = cur_op.alu_out[AW-1:0];
  assign take     = cur_op.j || (cur_op.jc && (cur_op.neq ? !cur_op.zero : cur_op.zero));

  // Memory is never cleared; a reset edge also blocks a completing write.
  always_ff @(posedge clock) begin
    if (reset_n && complete && cur_op.wm && in_range) mem[mem_idx] <= cur_op.reg_val;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.out_valid   <= 1'b0;
      bus.wr_mem      <= 1'b0;
      bus.rm_mem      <= 1'b0;
      bus.jump_taken  <= 1'b0;
      bus.addr_err    <= 1'b0;
      bus.rd_mem      <= '0;
      bus.alu_wb      <= '0;
      bus.data_out    <= '0;
      bus.jump_target <= '0;
    end else begin
      bus.out_valid  <= complete;
      bus.jump_taken <= 1'b0;
      bus.wr_mem     <= 1'b0;
      bus.addr_err   <= 1'b0;
      if (complete) begin
        bus.jump_taken  <= take;
        bus.wr_mem      <= cur_op.wr;
        bus.addr_err    <= mem_acc && !in_range;
        bus.rm_mem      <= cur_op.rm;
        bus.rd_mem      <= cur_op.rd_ex;
        bus.alu_wb      <= cur_op.alu_out;
        bus.jump_target <= cur_op.pc;
        bus.data_out    <= (cur_op.rm && in_range) ? mem[mem_idx] : '0;
      end
    end
  end
endmodule
